// File: rtl/afifo_rd_pkg.sv
// Shared types and default sizes for the async-FIFO burst reader.
package afifo_rd_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_LEN_W  = 6;
    localparam int unsigned DEF_TO_CYC = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_e;

endpackage

// File: rtl/afifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream seen by the burst reader.
interface afifo_burst_reader_if
    import afifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );

endinterface

// File: rtl/afifo_rd_outreg.sv
// One-entry output register: load wins over accept, contents hold while stalled.
module afifo_rd_outreg
    import afifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              accept,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && accept) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/afifo_burst_reader.sv
// Pops len words from a FWFT FIFO onto a valid/ready stream, then pulses done.
// Optional empty-stall timeout enabled by defining RD_TIMEOUT_EN.
module afifo_burst_reader
    import afifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned TO_CYC = DEF_TO_CYC
) (
    input  logic                  rclk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      rd_count,
    output logic                  err,
    afifo_burst_reader_if.master  bus
);

    rd_state_e        state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             pop;
    logic             accept;
    logic             launch;
    logic             timeout;

    assign accept = bus.m_valid && bus.m_ready;
    assign launch = (state == IDLE) && start && (len != '0);
    assign pop    = (state == RUN) && (remaining != '0) && !bus.fifo_empty
                    && (!bus.m_valid || bus.m_ready);

    assign bus.fifo_rd_en = pop;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign err            = timeout;

`ifdef RD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] stall_cnt;
    logic            stalled;

    assign stalled = (state == RUN) && bus.fifo_empty && (remaining != '0);
    assign timeout = stalled && (stall_cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if ((state != RUN) || pop) begin
            stall_cnt <= '0;
        end else if (stalled) begin
            stall_cnt <= stall_cnt + TO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (pop && (remaining == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   if (accept && bus.m_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            remaining <= '0;
            rd_count  <= '0;
        end else if (launch) begin
            remaining <= len;
            rd_count  <= '0;
        end else if (pop) begin
            remaining <= remaining - LEN_W'(1);
            rd_count  <= rd_count + LEN_W'(1);
        end
    end

    // After a timeout abort the held word (m_last=0) still drains from here while IDLE.
    afifo_rd_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk       (rclk),
        .rst_n     (rstn),
        .load      (pop),
        .load_data (bus.fifo_data),
        .load_last (remaining == LEN_W'(1)),
        .accept    (bus.m_ready),
        .valid     (bus.m_valid),
        .data      (bus.m_data),
        .last      (bus.m_last)
    );

endmodule

// File: tb/tb_afifo_burst_reader.sv
// Scoreboard bench for afifo_burst_reader with a queue-based FWFT FIFO model.
module tb_afifo_burst_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 6;
    localparam int unsigned TO = 64;

    logic          rclk  = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len   = '0;
    logic          busy, done, err;
    logic [LW-1:0] rd_count;

    afifo_burst_reader_if #(.DATA_W(DW)) bus ();

    afifo_burst_reader #(
        .DATA_W (DW),
        .LEN_W  (LW),
        .TO_CYC (TO)
    ) dut (
        .rclk     (rclk),
        .rstn     (rstn),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rd_count (rd_count),
        .err      (err),
        .bus      (bus)
    );

    always #5 rclk = ~rclk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    bit            pop_pending  = 1'b0;
    bit            ready_toggle = 1'b0;
    bit            prev_hold    = 1'b0;
    logic [DW-1:0] prev_data    = '0;
    int unsigned   cyc = 0, pop_cnt = 0, done_cnt = 0, err_cnt = 0;
    int unsigned   burst_len = 0, burst_pops = 0;
    int unsigned   start_cyc = 0, done_cyc = 0, last_cyc = 0, err_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // FIFO model and output monitor: inputs change at negedge+1, sampling at negedge+2.
    initial begin
        logic [DW:0] e;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        bus.m_ready    = 1'b1;
        forever begin
            @(negedge rclk);
            cyc++;
            if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_pending = 1'b0;
            #1;
            bus.fifo_empty = (fifo_q.size() == 0);
            bus.fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
            bus.m_ready    = ready_toggle ? ~bus.m_ready : 1'b1;
            #1;
            if (!rstn) begin
                prev_hold = 1'b0;
            end else begin
                if (start) start_cyc = cyc;
                if (prev_hold) begin
                    check_eq("hold_valid", bus.m_valid, 1);
                    check_eq("hold_data", bus.m_data, prev_data);
                end
                if (bus.fifo_empty) check_eq("no_pop_empty", bus.fifo_rd_en, 0);
                if (bus.m_valid && !bus.m_ready) check_eq("no_pop_hold", bus.fifo_rd_en, 0);
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_word", bus.m_data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("m_data", bus.m_data, e[DW-1:0]);
                        check_eq("m_last", bus.m_last, e[DW]);
                        if (bus.m_last) last_cyc = cyc;
                    end
                end
                if (bus.fifo_rd_en && !bus.fifo_empty) begin
                    burst_pops++;
                    pop_cnt++;
                    exp_q.push_back({burst_pops == burst_len, fifo_q[0]});
                    pop_pending = 1'b1;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (err) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                prev_hold = bus.m_valid && !bus.m_ready;
                prev_data = bus.m_data;
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge rclk);
    endtask

    task automatic begin_burst(input int unsigned n);
        @(negedge rclk);
        start      = 1'b1;
        len        = LW'(n);
        burst_len  = n;
        burst_pops = 0;
        @(negedge rclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned d0, input int unsigned lim);
        int unsigned k = 0;
        while (done_cnt == d0 && k < lim) begin
            @(negedge rclk);
            k++;
        end
        check_eq("done_seen", done_cnt != d0, 1);
    endtask

    task automatic check_idle(input string tag);
        #3;
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_rd_count"}, rd_count, 0);
        check_eq({tag, "_m_valid"}, bus.m_valid, 0);
        check_eq({tag, "_m_data"}, bus.m_data, 0);
        check_eq({tag, "_m_last"}, bus.m_last, 0);
        check_eq({tag, "_rd_en"}, bus.fifo_rd_en, 0);
    endtask

    initial begin
        int unsigned d0, p0, e0;

        tick(3);
        check_idle("rst0");
        rstn = 1'b1;
        tick(2);

        // Basic burst of 4 at full throughput.
        fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        d0 = done_cnt; p0 = pop_cnt;
        begin_burst(4);
        wait_done(d0, 50);
        check_eq("b4_latency", done_cyc - start_cyc, 6);
        check_eq("b4_done_after_last", done_cyc - last_cyc, 1);
        #3 check_eq("b4_rd_count", rd_count, 4);
        tick(3);
        check_eq("b4_pops", pop_cnt - p0, 4);
        check_eq("b4_done_once", done_cnt - d0, 1);
        check_eq("b4_sb_empty", exp_q.size(), 0);

        // Backpressure, plus a start while busy that must be ignored.
        ready_toggle = 1'b1;
        fifo_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        d0 = done_cnt; p0 = pop_cnt;
        begin_burst(3);
        tick(1);
        start = 1'b1;
        len   = LW'(2);
        @(negedge rclk);
        start = 1'b0;
        wait_done(d0, 50);
        ready_toggle = 1'b0;
        tick(4);
        check_eq("bp_pops", pop_cnt - p0, 3);
        check_eq("bp_done_once", done_cnt - d0, 1);
        check_eq("bp_sb_empty", exp_q.size(), 0);
        check_eq("bp_busy_end", busy, 0);

        // Zero-length start with data available.
        d0 = done_cnt; p0 = pop_cnt;
        @(negedge rclk);
        start = 1'b1;
        len   = '0;
        @(negedge rclk);
        start = 1'b0;
        tick(4);
        #3;
        check_eq("len0_busy", busy, 0);
        check_eq("len0_done", done_cnt - d0, 0);
        check_eq("len0_pops", pop_cnt - p0, 0);
        @(negedge rclk);
        fifo_q.delete();

        // FIFO runs dry mid-burst, refilled 20 cycles later.
        fifo_q = '{8'h41, 8'h42};
        d0 = done_cnt; p0 = pop_cnt;
        begin_burst(5);
        tick(20);
        #3;
        check_eq("stall_busy", busy, 1);
        check_eq("stall_pops", pop_cnt - p0, 2);
        check_eq("stall_done", done_cnt - d0, 0);
        @(negedge rclk);
        fifo_q.push_back(8'h43);
        fifo_q.push_back(8'h44);
        fifo_q.push_back(8'h45);
        wait_done(d0, 50);
        #3 check_eq("stall_rd_count", rd_count, 5);
        tick(3);
        check_eq("stall_pops_total", pop_cnt - p0, 5);
        check_eq("stall_done_once", done_cnt - d0, 1);

        // Starved burst: times out with the macro, waits forever without it.
        fifo_q = '{8'h61};
        d0 = done_cnt; p0 = pop_cnt; e0 = err_cnt;
        begin_burst(4);
`ifdef RD_TIMEOUT_EN
        begin
            int unsigned k = 0;
            while (err_cnt == e0 && k < 120) begin
                @(negedge rclk);
                k++;
            end
        end
        check_eq("to_err_seen", err_cnt - e0, 1);
        check_eq("to_err_cycle", err_cyc - start_cyc, 65);
        tick(2);
        #3;
        check_eq("to_busy", busy, 0);
        check_eq("to_rd_count", rd_count, 1);
        check_eq("to_no_done", done_cnt - d0, 0);
        check_eq("to_err_once", err_cnt - e0, 1);
        check_eq("to_sb_empty", exp_q.size(), 0);
        fifo_q = '{8'h62};
        begin_burst(4);
        tick(5);
`else
        tick(80);
        #3;
        check_eq("nto_busy", busy, 1);
        check_eq("nto_err", err_cnt - e0, 0);
        check_eq("nto_rd_count", rd_count, 1);
        check_eq("nto_no_done", done_cnt - d0, 0);
`endif

        // Reset mid-burst; start held high during reset must be ignored.
        @(negedge rclk);
        rstn  = 1'b0;
        start = 1'b1;
        len   = LW'(3);
        fifo_q.push_back(8'h70);
        check_idle("rst_mid");
        tick(3);
        check_idle("rst_hold");
        exp_q.delete();
        @(negedge rclk);
        fifo_q.delete();
        start = 1'b0;
        @(negedge rclk);
        rstn = 1'b1;
        tick(2);
        #3 check_eq("rst_exit_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
